// File: rtl/shake_squeeze_arbiter.sv
// Two-requester round-robin arbiter that shares one shake128 squeeze core.
// Define SQZ_ARB_TIMEOUT_EN to compile in a WAIT-state watchdog driving err_timeout.
module shake_squeeze_arbiter #(
  parameter int unsigned STATE_W        = 1600,
  parameter int unsigned NB_W           = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_0,
  input  logic [STATE_W-1:0] s_in_0,
  input  logic [NB_W-1:0]    nblocks_0,
  output logic               gnt_0,
  output logic               done_0,
  input  logic               req_1,
  input  logic [STATE_W-1:0] s_in_1,
  input  logic [NB_W-1:0]    nblocks_1,
  output logic               gnt_1,
  output logic               done_1,
  output logic               core_start,
  output logic [STATE_W-1:0] core_s_in,
  output logic [NB_W-1:0]    core_nblocks,
  input  logic               core_done,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic               r_owner;
  logic               r_ptr;
  logic               r_core_start;
  logic [STATE_W-1:0] r_s_in;
  logic [NB_W-1:0]    r_nblocks;

  logic               w_grant;
  logic               w_sel;
  logic               w_start_d;
  logic               w_timeout;

  // Pointer only breaks ties; a lone request wins regardless of it.
  always_comb begin
    w_grant = (r_state == StIdle) && (req_0 || req_1);
    if (req_0 && req_1) begin
      w_sel = r_ptr;
    end else begin
      w_sel = req_1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_start_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant) w_state_d = StLaunch;
      end
      StLaunch: begin
        // Zero-block jobs never touch the core.
        if (r_nblocks == '0) begin
          w_state_d = StDone;
        end else begin
          w_state_d = StWait;
          w_start_d = 1'b1;
        end
      end
      StWait: begin
        if (core_done || w_timeout) w_state_d = StDone;
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_ptr        <= 1'b0;
      r_core_start <= 1'b0;
      r_s_in       <= '0;
      r_nblocks    <= '0;
    end else begin
      r_state      <= w_state_d;
      r_core_start <= w_start_d;
      if (w_grant) begin
        r_owner   <= w_sel;
        r_s_in    <= w_sel ? s_in_1 : s_in_0;
        r_nblocks <= w_sel ? nblocks_1 : nblocks_0;
      end
      if (r_state == StDone) r_ptr <= ~r_ptr;
    end
  end

`ifdef SQZ_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_err;

  // core_done on the last allowed cycle still counts as a normal completion.
  assign w_timeout = (r_state == StWait) && !core_done && (r_wd_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wd_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == StLaunch) begin
        r_wd_cnt <= '0;
      end else if (r_state == StWait) begin
        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
      if (w_grant) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_timeout = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  assign busy         = (r_state != StIdle);
  assign gnt_0        = busy && !r_owner;
  assign gnt_1        = busy && r_owner;
  assign done_0       = (r_state == StDone) && !r_owner;
  assign done_1       = (r_state == StDone) && r_owner;
  assign core_start   = r_core_start;
  assign core_s_in    = r_s_in;
  assign core_nblocks = r_nblocks;

endmodule

// File: tb/tb_shake_squeeze_arbiter.sv
// Self-checking bench for shake_squeeze_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin model.
module tb_shake_squeeze_arbiter;
  localparam int unsigned STATE_W        = 64;
  localparam int unsigned NB_W           = 16;
  localparam int unsigned TIMEOUT_CYCLES = 16;
`ifdef SQZ_ARB_TIMEOUT_EN
  localparam int SINGLE_LAT = 10;
`else
  localparam int SINGLE_LAT = 120;
`endif

  logic               clock = 1'b0;
  logic               reset;
  logic               req_0, req_1;
  logic [STATE_W-1:0] s_in_0, s_in_1;
  logic [NB_W-1:0]    nblocks_0, nblocks_1;
  logic               gnt_0, gnt_1, done_0, done_1;
  logic               core_start;
  logic [STATE_W-1:0] core_s_in;
  logic [NB_W-1:0]    core_nblocks;
  logic               core_done;
  logic               busy, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit m_ptr   = 1'b0;

  shake_squeeze_arbiter #(
    .STATE_W        (STATE_W),
    .NB_W           (NB_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_0        (req_0),
    .s_in_0       (s_in_0),
    .nblocks_0    (nblocks_0),
    .gnt_0        (gnt_0),
    .done_0       (done_0),
    .req_1        (req_1),
    .s_in_1       (s_in_1),
    .nblocks_1    (nblocks_1),
    .gnt_1        (gnt_1),
    .done_1       (done_1),
    .core_start   (core_start),
    .core_s_in    (core_s_in),
    .core_nblocks (core_nblocks),
    .core_done    (core_done),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] obs();
    return {gnt_0, gnt_1, done_0, done_1, core_start, busy, err_timeout};
  endfunction

  // w: owner, g: granted/busy, d: done pulse, s: core_start, e: err_timeout
  function automatic logic [6:0] ev(input bit w, input bit g, input bit d, input bit s,
                                    input bit e);
    return {g && !w, g && w, d && !w, d && w, s, g, e};
  endfunction

  function automatic logic [STATE_W-1:0] rand_state();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_req(input int r, input logic v);
    if (r == 0) req_0 = v;
    else req_1 = v;
  endtask

  task automatic drive_s(input int r, input logic [STATE_W-1:0] v);
    if (r == 0) s_in_0 = v;
    else s_in_1 = v;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_0 = 1'b0; req_1 = 1'b0; core_done = 1'b0;
    s_in_0 = '0; s_in_1 = '0; nblocks_0 = '0; nblocks_1 = '0;
    #3;
    n_tests++;
    if ({obs(), core_s_in, core_nblocks} !== '0) begin
      n_fail++;
      $display("FAIL reset_asserted: outputs=%b s=%h nb=%h, required all zero",
               obs(), core_s_in, core_nblocks);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (obs() !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%b, required 0000000", obs());
    end
    m_ptr = 1'b0;
  endtask

  task automatic test_single();
    logic [STATE_W-1:0] s;
    int extra = 0, early = 0, lost = 0;
    s = rand_state();
    req_0 = 1'b1; nblocks_0 = 16'd5; s_in_0 = s;
    tick();
    n_tests++;
    if (obs() !== ev(0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL single_grant: outputs=%b, required %b", obs(), ev(0, 1, 0, 0, 0));
    end
    tick();
    n_tests++;
    if ({obs(), core_s_in, core_nblocks} !== {ev(0, 1, 0, 1, 0), s, 16'd5}) begin
      n_fail++;
      $display("FAIL single_start: outputs=%b nb=%0d s=%h, required %b nb=5 s=%h",
               obs(), core_nblocks, core_s_in, ev(0, 1, 0, 1, 0), s);
    end
    for (int i = 0; i < SINGLE_LAT - 1; i++) begin
      tick();
      if (core_start) extra++;
      if (done_0 || done_1) early++;
      if (!gnt_0 || gnt_1) lost++;
    end
    n_tests++;
    if ({extra, early, lost} !== {32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL single_wait: extra_starts=%0d early_done=%0d bad_gnt=%0d, required 0/0/0",
               extra, early, lost);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    req_0 = 1'b0;
    n_tests++;
    if (obs() !== ev(0, 1, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL single_done: outputs=%b, required %b", obs(), ev(0, 1, 1, 0, 0));
    end
    tick();
    n_tests++;
    if (obs() !== 7'b0) begin
      n_fail++;
      $display("FAIL single_idle: outputs=%b, required 0000000", obs());
    end
    m_ptr = ~m_ptr;
  endtask

  task automatic test_simultaneous();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    m_ptr = 1'b0;
    nblocks_0 = 16'd1; nblocks_1 = 16'd1;
    for (int k = 0; k < 4; k++) begin
      bit w;
      w = (k % 2) == 1;
      req_0 = 1'b1; req_1 = 1'b1;
      tick();
      n_tests++;
      if (obs() !== ev(w, 1, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: outputs=%b, required %b", k, obs(), ev(w, 1, 0, 0, 0));
      end
      tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      n_tests++;
      if (obs() !== ev(w, 1, 1, 0, 0)) begin
        n_fail++;
        $display("FAIL rr_done_%0d: outputs=%b, required %b", k, obs(), ev(w, 1, 1, 0, 0));
      end
      drive_req(int'(w), 1'b0);
      tick();
      m_ptr = ~m_ptr;
    end
    req_0 = 1'b0; req_1 = 1'b0;
  endtask

  task automatic test_zero_block();
    req_1 = 1'b1; nblocks_1 = '0;
    tick();
    n_tests++;
    if (obs() !== ev(1, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL zero_grant: outputs=%b, required %b", obs(), ev(1, 1, 0, 0, 0));
    end
    tick();
    n_tests++;
    if (obs() !== ev(1, 1, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL zero_done: outputs=%b, required %b", obs(), ev(1, 1, 1, 0, 0));
    end
    req_1 = 1'b0;
    tick();
    n_tests++;
    if (obs() !== 7'b0) begin
      n_fail++;
      $display("FAIL zero_idle: outputs=%b, required 0000000", obs());
    end
    m_ptr = ~m_ptr;
  endtask

  task automatic test_stability();
    logic [STATE_W-1:0] a;
    a = rand_state();
    req_0 = 1'b1; nblocks_0 = 16'd2; s_in_0 = a;
    tick();
    for (int i = 0; i < 4; i++) begin
      s_in_0 = ~a ^ rand_state();
      nblocks_0 = NB_W'($urandom);
      tick();
      n_tests++;
      if ({core_s_in, core_nblocks} !== {a, 16'd2}) begin
        n_fail++;
        $display("FAIL stable_%0d: s=%h nb=%0d, required s=%h nb=2", i, core_s_in,
                 core_nblocks, a);
      end
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    req_0 = 1'b0;
    n_tests++;
    if ({obs(), core_s_in} !== {ev(0, 1, 1, 0, 0), a}) begin
      n_fail++;
      $display("FAIL stable_done: outputs=%b s=%h, required %b s=%h", obs(), core_s_in,
               ev(0, 1, 1, 0, 0), a);
    end
    tick();
    m_ptr = ~m_ptr;
  endtask

  task automatic test_reset_in_wait();
    // Move the pointer to requester 1 first so the post-reset grant proves it was cleared.
    req_0 = 1'b1; nblocks_0 = '0;
    tick(); tick();
    req_0 = 1'b0;
    tick();
    m_ptr = ~m_ptr;
    req_1 = 1'b1; nblocks_1 = 16'd3; s_in_1 = rand_state();
    tick(); tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({obs(), core_s_in, core_nblocks} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_async: outputs=%b s=%h nb=%h, required all zero",
               obs(), core_s_in, core_nblocks);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    n_tests++;
    if (obs() !== 7'b0) begin
      n_fail++;
      $display("FAIL rst_wait_hold: outputs=%b, required 0000000", obs());
    end
    reset = 1'b1;
    m_ptr = 1'b0;
    req_0 = 1'b1; nblocks_0 = 16'd1;
    tick();
    n_tests++;
    if (obs() !== ev(0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL rst_wait_regrant: outputs=%b, required %b", obs(), ev(0, 1, 0, 0, 0));
    end
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
    m_ptr = ~m_ptr;
  endtask

  task automatic test_watchdog();
    req_0 = 1'b1; nblocks_0 = 16'd2;
    tick(); tick();
`ifdef SQZ_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      n_tests++;
      if (obs() !== ev(0, 1, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL wd_wait_%0d: outputs=%b, required %b", i, obs(), ev(0, 1, 0, 0, 0));
      end
    end
    tick();
    n_tests++;
    if (obs() !== ev(0, 1, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL wd_expire: outputs=%b, required %b", obs(), ev(0, 1, 1, 0, 1));
    end
    req_0 = 1'b0;
    tick();
    n_tests++;
    if (obs() !== 7'b0000001) begin
      n_fail++;
      $display("FAIL wd_sticky: outputs=%b, required 0000001", obs());
    end
    m_ptr = ~m_ptr;
    req_0 = 1'b1; nblocks_0 = '0;
    tick();
    n_tests++;
    if (obs() !== ev(0, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL wd_clear: outputs=%b, required %b", obs(), ev(0, 1, 0, 0, 0));
    end
    tick();
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      n_tests++;
      if (obs() !== ev(0, 1, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL nowd_wait_%0d: outputs=%b, required %b", i, obs(), ev(0, 1, 0, 0, 0));
      end
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_tests++;
    if (obs() !== ev(0, 1, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL nowd_done: outputs=%b, required %b", obs(), ev(0, 1, 1, 0, 0));
    end
`endif
    req_0 = 1'b0;
    tick();
    m_ptr = ~m_ptr;
  endtask

  task automatic test_random();
    bit                 pend[2];
    logic [STATE_W-1:0] ms[2];
    logic [NB_W-1:0]    mn[2];
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      bit w;
      int lat;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) pend[r] = 1'b1;
        else if (!pend[r]) continue;
        else continue;
        ms[r] = rand_state();
        mn[r] = ($urandom_range(0, 3) == 0) ? '0 : NB_W'($urandom_range(1, 300));
      end
      if (!pend[0] && !pend[1]) begin
        int r;
        r = $urandom_range(0, 1);
        pend[r] = 1'b1;
        ms[r] = rand_state();
        mn[r] = NB_W'($urandom_range(0, 7));
      end
      req_0 = pend[0]; s_in_0 = ms[0]; nblocks_0 = mn[0];
      req_1 = pend[1]; s_in_1 = ms[1]; nblocks_1 = mn[1];
      w = (pend[0] && pend[1]) ? m_ptr : pend[1];
      tick();
      n_tests++;
      if (obs() !== ev(w, 1, 0, 0, 0)) begin
        n_fail++;
        $display("FAIL rnd_grant_%0d: outputs=%b, required %b", it, obs(), ev(w, 1, 0, 0, 0));
      end
      if ($urandom_range(0, 3) == 0) drive_req(int'(w), 1'b0);
      drive_s(int'(w), rand_state());
      core_done = ($urandom_range(0, 2) == 0);
      tick();
      core_done = 1'b0;
      if (mn[w] == '0) begin
        n_tests++;
        if (obs() !== ev(w, 1, 1, 0, 0)) begin
          n_fail++;
          $display("FAIL rnd_zero_%0d: outputs=%b, required %b", it, obs(), ev(w, 1, 1, 0, 0));
        end
      end else begin
        n_tests++;
        if ({obs(), core_s_in, core_nblocks} !== {ev(w, 1, 0, 1, 0), ms[w], mn[w]}) begin
          n_fail++;
          $display("FAIL rnd_start_%0d: outputs=%b s=%h nb=%0d, required %b s=%h nb=%0d",
                   it, obs(), core_s_in, core_nblocks, ev(w, 1, 0, 1, 0), ms[w], mn[w]);
        end
        lat = $urandom_range(0, 12);
        for (int i = 0; i < lat; i++) begin
          tick();
          n_tests++;
          if ({obs(), core_s_in, core_nblocks} !== {ev(w, 1, 0, 0, 0), ms[w], mn[w]}) begin
            n_fail++;
            $display("FAIL rnd_wait_%0d: outputs=%b s=%h nb=%0d, required %b s=%h nb=%0d",
                     it, obs(), core_s_in, core_nblocks, ev(w, 1, 0, 0, 0), ms[w], mn[w]);
          end
        end
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        n_tests++;
        if (obs() !== ev(w, 1, 1, 0, 0)) begin
          n_fail++;
          $display("FAIL rnd_done_%0d: outputs=%b, required %b", it, obs(), ev(w, 1, 1, 0, 0));
        end
      end
      drive_req(int'(w), 1'b0);
      pend[w] = 1'b0;
      m_ptr = ~m_ptr;
      tick();
      n_tests++;
      if (obs() !== 7'b0) begin
        n_fail++;
        $display("FAIL rnd_gap_%0d: outputs=%b, required 0000000", it, obs());
      end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_block();
    test_stability();
    test_reset_in_wait();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
